// File: rtl/kbd_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard controller.
package kbd_pkg;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } kbd_event_t;

  localparam logic [7:0] SC_EXT        = 8'hE0;
  localparam logic [7:0] SC_BRK        = 8'hF0;
  localparam logic [7:0] SC_PAUSE      = 8'hE1;
  localparam logic [7:0] SC_BAT        = 8'hAA;
  localparam logic [7:0] SC_ACK        = 8'hFA;
  localparam logic [7:0] SC_ECHO       = 8'hEE;
  localparam logic [7:0] SC_RESEND     = 8'hFE;
  localparam logic [7:0] SC_FAKE_SHIFT = 8'h12;
  localparam logic [7:0] SC_PAUSE_KEY  = 8'h77;
  localparam logic [7:0] SC_ERR_LO     = 8'h00;
  localparam logic [7:0] SC_ERR_HI     = 8'hFF;

  localparam logic [2:0] PAUSE_TAIL_LEN = 3'd7;

  typedef enum logic {S_IDLE, S_POP} drain_state_e;

  // Keyboard replies that carry no key information.
  function automatic logic is_kbd_reply(input logic [7:0] b);
    return (b == SC_BAT) || (b == SC_ACK) || (b == SC_ECHO) || (b == SC_RESEND);
  endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// Small power-of-two event queue; head reads as zero while empty.
module kbd_event_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  kbd_event_t push_data,
  input  logic       pop,
  output kbd_event_t pop_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  kbd_event_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign pop_data = empty ? kbd_event_t'('0) : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The producer gates on full before fetching a byte, so this must never fire.
  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// Drains the PS/2 receiver FIFO and decodes set-2 bytes into key events.
// Optional typematic-repeat filter: define PS2_KBD_CTRL_REPEAT_FILTER_EN.
module ps2_kbd_ctrl
  import kbd_pkg::*;
#(
  parameter int EVQ_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_ready,
  input  logic [7:0] ps2_data,
  input  logic       ps2_overflow,
  output logic       nextdata_n,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [9:0] ev_data,
  output logic       err,
  input  logic       err_clr
);

  drain_state_e state_q, state_d;
  logic [7:0]   byte_q, byte_d;
  logic         nd_d;
  logic         ext_p, ext_d, brk_p, brk_d;
  logic [2:0]   pause_cnt, pcnt_d;
  logic         ovf_q, dec_err, err_set;
  logic         push, full, empty;
  kbd_event_t   push_ev, head_ev;

`ifdef PS2_KBD_CTRL_REPEAT_FILTER_EN
  logic [511:0] down_q;
  logic [8:0]   bm_idx;
  logic         bm_wr, bm_val;
`endif

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    nd_d    = 1'b1;
    ext_d   = ext_p;
    brk_d   = brk_p;
    pcnt_d  = pause_cnt;
    push    = 1'b0;
    push_ev = '0;
    dec_err = 1'b0;
`ifdef PS2_KBD_CTRL_REPEAT_FILTER_EN
    bm_idx  = {ext_p, byte_q};
    bm_wr   = 1'b0;
    bm_val  = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (ps2_ready && !full) begin
          byte_d  = ps2_data;
          nd_d    = 1'b0;
          state_d = S_POP;
        end
      end
      S_POP: begin
        state_d = S_IDLE;
        if (pause_cnt != 3'd0) begin
          // The pause tail is fixed-length, so it is counted rather than parsed.
          pcnt_d = pause_cnt - 3'd1;
          if (pause_cnt == 3'd1) begin
            push    = 1'b1;
            push_ev = '{brk: 1'b0, ext: 1'b1, code: SC_PAUSE_KEY};
          end
        end else if (byte_q == SC_PAUSE) begin
          pcnt_d = PAUSE_TAIL_LEN;
        end else if (byte_q == SC_EXT) begin
          ext_d = 1'b1;
        end else if (byte_q == SC_BRK) begin
          brk_d = 1'b1;
        end else if (byte_q == SC_ERR_LO || byte_q == SC_ERR_HI) begin
          dec_err = 1'b1;
          ext_d   = 1'b0;
          brk_d   = 1'b0;
        end else if (is_kbd_reply(byte_q) && !ext_p && !brk_p) begin
          push = 1'b0;
        end else if (byte_q == SC_FAKE_SHIFT && ext_p) begin
          ext_d = 1'b0;
          brk_d = 1'b0;
        end else begin
          ext_d   = 1'b0;
          brk_d   = 1'b0;
          push_ev = '{brk: brk_p, ext: ext_p, code: byte_q};
`ifdef PS2_KBD_CTRL_REPEAT_FILTER_EN
          if (brk_p) begin
            bm_wr = 1'b1;
            push  = 1'b1;
          end else if (!down_q[bm_idx]) begin
            bm_wr  = 1'b1;
            bm_val = 1'b1;
            push   = 1'b1;
          end
`else
          push = 1'b1;
`endif
        end
      end
    endcase
  end

  assign err_set = dec_err | (ps2_overflow & ~ovf_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      byte_q     <= '0;
      nextdata_n <= 1'b1;
      ext_p      <= 1'b0;
      brk_p      <= 1'b0;
      pause_cnt  <= '0;
      ovf_q      <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      nextdata_n <= nd_d;
      ext_p      <= ext_d;
      brk_p      <= brk_d;
      pause_cnt  <= pcnt_d;
      ovf_q      <= ps2_overflow;
      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

`ifdef PS2_KBD_CTRL_REPEAT_FILTER_EN
  always_ff @(posedge clk) begin
    if (rst)        down_q <= '0;
    else if (bm_wr) down_q[bm_idx] <= bm_val;
  end
`endif

  kbd_event_fifo #(.DEPTH(EVQ_DEPTH)) u_evq (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_ev),
    .pop       (ev_valid & ev_ready),
    .pop_data  (head_ev),
    .full      (full),
    .empty     (empty)
  );

  assign ev_valid = !empty;
  assign ev_data  = head_ev;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Randomized bench for ps2_kbd_ctrl with a byte-stream reference model.
module tb_ps2_kbd_ctrl;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_ready = 1'b0;
  logic [7:0] ps2_data = 8'h00;
  logic       ps2_overflow = 1'b0;
  logic       nextdata_n;
  logic       ev_valid;
  logic       ev_ready = 1'b0;
  logic [9:0] ev_data;
  logic       err;
  logic       err_clr = 1'b0;

  ps2_kbd_ctrl #(.EVQ_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2_ready    (ps2_ready),
    .ps2_data     (ps2_data),
    .ps2_overflow (ps2_overflow),
    .nextdata_n   (nextdata_n),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_data      (ev_data),
    .err          (err),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  // receiver FIFO, stimulus controls and model state
  logic [7:0] rx_q[$];
  logic [7:0] feed_q[$];
  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];
  bit   rst_drv = 1'b1, ready_drv = 1'b1, clr_drv = 1'b0, ovf_drv = 1'b0;
  bit   m_ext = 1'b0, m_brk = 1'b0, m_err = 1'b0, ovf_old = 1'b0, prev_nd_low = 1'b0;
  int   m_pcnt = 0, pops = 0;
`ifdef PS2_KBD_CTRL_REPEAT_FILTER_EN
  bit   m_down [512];
`endif

  logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'hAA, 8'hFA,
                            8'h1C, 8'h1B, 8'h23, 8'h75, 8'h77, 8'h14};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // One received byte applied to the key-event rules; returns whether it is an error byte.
  task automatic model_byte(input logic [7:0] b, output bit is_err);
    logic [8:0] idx;
    is_err = 1'b0;
    if (m_pcnt != 0) begin
      m_pcnt--;
      if (m_pcnt == 0) exp_q.push_back({1'b0, 1'b1, 8'h77});
    end else if (b == 8'hE1) m_pcnt = 7;
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'h00 || b == 8'hFF) begin
      is_err = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
    end else if ((b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE) && !m_ext && !m_brk) begin
      is_err = 1'b0;
    end else if (b == 8'h12 && m_ext) begin
      m_ext = 1'b0; m_brk = 1'b0;
    end else begin
      idx = {m_ext, b};
`ifdef PS2_KBD_CTRL_REPEAT_FILTER_EN
      if (m_brk) begin
        m_down[idx] = 1'b0;
        exp_q.push_back({m_brk, m_ext, b});
      end else if (!m_down[idx]) begin
        m_down[idx] = 1'b1;
        exp_q.push_back({m_brk, m_ext, b});
      end
`else
      exp_q.push_back({m_brk, m_ext, b});
`endif
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  // One cycle: compare at the negedge, then drive inputs and advance the model to the next edge.
  task automatic step();
    logic [7:0] b;
    bit de, set;
    @(negedge clk);
    chk("ev_valid", ev_valid, exp_q.size() != 0);
    chk("ev_data", ev_data, (exp_q.size() != 0) ? exp_q[0] : 10'h000);
    chk("err", err, m_err);
    if (rst) chk("nd_reset", nextdata_n, 1);
    else if (prev_nd_low) chk("nd_one_cycle", nextdata_n, 1);
    prev_nd_low = !nextdata_n && !rst;

    rst = rst_drv; ev_ready = ready_drv; err_clr = clr_drv; ps2_overflow = ovf_drv;
    if (rst) begin
      rx_q.delete(); exp_q.delete();
      m_ext = 1'b0; m_brk = 1'b0; m_pcnt = 0; m_err = 1'b0; ovf_old = 1'b0;
`ifdef PS2_KBD_CTRL_REPEAT_FILTER_EN
      foreach (m_down[i]) m_down[i] = 1'b0;
`endif
    end else begin
      if (ev_valid && ev_ready) got_q.push_back(ev_data);
      if (ev_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      de = 1'b0;
      if (!nextdata_n) begin
        chk("pop_nonempty", rx_q.size() != 0, 1);
        if (rx_q.size() != 0) begin
          b = rx_q.pop_front();
          pops++;
          model_byte(b, de);
        end
      end
      set = de | (ps2_overflow & ~ovf_old);
      ovf_old = ps2_overflow;
      if (set) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      foreach (feed_q[i]) rx_q.push_back(feed_q[i]);
    end
    feed_q.delete();
    ps2_ready = (rx_q.size() != 0);
    ps2_data  = ps2_ready ? rx_q[0] : 8'h00;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_drv = 1'b1; run(2);
    rst_drv = 1'b0; run(1);
    got_q.delete(); pops = 0;
  endtask

  task automatic feed(input logic [7:0] b);
    feed_q.push_back(b);
  endtask

  initial begin
    logic [7:0] b;
    int r;
    do_reset();

    // latency of a single make
    ready_drv = 1'b1;
    feed(8'h1C); step();
    step(); chk("lat_nd_low", nextdata_n, 0);
    step(); chk("lat_valid", ev_valid, 1); chk("lat_data", ev_data, 10'h01C);
    run(4);

    // extended break: three pops, one event
    do_reset();
    feed(8'hE0); feed(8'hF0); feed(8'h75); run(12);
    chk("ext_brk_pops", pops, 3);
    chk("ext_brk_count", got_q.size(), 1);
    chk("ext_brk_event", (got_q.size() != 0) ? got_q[0] : 10'h0, 10'h375);

    // pause sequence collapses to one event
    do_reset();
    foreach (pool[i]) if (i < 0) b = pool[i];
    feed(8'hE1); feed(8'h14); feed(8'h77); feed(8'hE1);
    feed(8'hF0); feed(8'h14); feed(8'hF0); feed(8'h77); run(24);
    chk("pause_pops", pops, 8);
    chk("pause_count", got_q.size(), 1);
    chk("pause_event", (got_q.size() != 0) ? got_q[0] : 10'h0, 10'h177);

    // backpressure: queue fills, remaining bytes stay in the receiver
    do_reset();
    ready_drv = 1'b0;
    feed(8'h1C); feed(8'h1B); feed(8'h23); feed(8'h2B); feed(8'h34); feed(8'h33);
    run(30);
    chk("bp_pops", pops, 4);
    chk("bp_rx_left", rx_q.size(), 2);
    chk("bp_nd_high", nextdata_n, 1);
    ready_drv = 1'b1; run(20);
    chk("bp_delivered", got_q.size(), 6);
    chk("bp_last", (got_q.size() == 6) ? got_q[5] : 10'h0, 10'h033);

    // error flag: bad byte, clear, overflow rise
    do_reset();
    feed(8'h00); run(4);
    chk("err_byte", err, 1);
    clr_drv = 1'b1; step(); clr_drv = 1'b0; step();
    chk("err_cleared", err, 0);
    ovf_drv = 1'b1; run(3);
    chk("err_ovf", err, 1);
    ovf_drv = 1'b0; clr_drv = 1'b1; step(); clr_drv = 1'b0; run(2);
    chk("err_ovf_cleared", err, 0);

    // typematic repeat
    do_reset();
    feed(8'h1C); feed(8'h1C); feed(8'h1C); feed(8'hF0); feed(8'h1C); feed(8'h1C);
    run(20);
`ifdef PS2_KBD_CTRL_REPEAT_FILTER_EN
    chk("rep_count", got_q.size(), 3);
    chk("rep_break", (got_q.size() == 3) ? got_q[1] : 10'h0, 10'h21C);
`else
    chk("rep_count", got_q.size(), 5);
    chk("rep_break", (got_q.size() == 5) ? got_q[3] : 10'h0, 10'h21C);
`endif

    // reset while a prefix byte is being popped discards it
    do_reset();
    feed(8'hE0); step();
    rst_drv = 1'b1; step(); chk("rstpop_nd_low", nextdata_n, 0);
    rst_drv = 1'b0; step();
    feed(8'h75); run(8);
    chk("rstpop_event", (got_q.size() != 0) ? got_q[got_q.size()-1] : 10'h0, 10'h075);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (rx_q.size() < 8 && $urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 99);
        if (r == 0) b = 8'h00;
        else if (r == 1) b = 8'hFF;
        else b = pool[$urandom_range(0, 11)];
        feed(b);
      end
      ready_drv = ($urandom_range(0, 3) != 0);
      clr_drv   = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 59) == 0) ovf_drv = ~ovf_drv;
      if (c == 1500) rst_drv = 1'b1;
      else rst_drv = 1'b0;
      step();
    end
    ready_drv = 1'b1; clr_drv = 1'b0;
    for (int i = 0; i < 200 && (rx_q.size() != 0 || exp_q.size() != 0); i++) step();
    chk("drain_done", rx_q.size() + exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
